// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: power-up, settle, gated count window,
// averager handshake and result capture, with optional periodic re-arm.
module ro_meas_sequencer #(
    parameter int SETTLE_CYC  = 16,
    parameter int WIN_W       = 16,
    parameter int RES_W       = 8,
    parameter int ACC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             abort,
    input  logic [WIN_W-1:0] window_len,
    input  logic [15:0]      idle_gap,
    input  logic             avg_ready,
    input  logic [RES_W-1:0] avg_result,
    input  logic             result_ack,
    output logic             ro_en,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             avg_en,
    output logic             avg_sum_en,
    output logic             busy,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             overrun,
    output logic             timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CLEAR   = 3'd2;
    localparam logic [2:0] S_WINDOW  = 3'd3;
    localparam logic [2:0] S_ACCUM   = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;

    logic [2:0]       state, state_nx;
    logic [15:0]      cnt;
    logic [WIN_W-1:0] win_len;
    logic [15:0]      gap_len;
    logic             accept, to_hit, capture;

    assign accept  = (state == S_IDLE) && start && !abort;
    assign capture = (state == S_CAPTURE) && !abort;

    always_comb begin
        state_nx = state;
        to_hit   = 1'b0;
        case (state)
            S_IDLE:    if (accept) state_nx = S_SETTLE;
            S_SETTLE:  if (int'(cnt) >= SETTLE_CYC - 1) state_nx = S_CLEAR;
            S_CLEAR:   state_nx = S_WINDOW;
            S_WINDOW:  if (int'(cnt) >= int'(win_len) - 1) state_nx = S_ACCUM;
            S_ACCUM: begin
                if (avg_ready) begin
                    state_nx = S_CAPTURE;
                end else if (int'(cnt) >= ACC_TIMEOUT - 1) begin
                    state_nx = S_IDLE;
                    to_hit   = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (!cont_mode)          state_nx = S_IDLE;
                else if (gap_len == '0)  state_nx = S_SETTLE;
                else                     state_nx = S_GAP;
            end
            S_GAP: begin
                if (!cont_mode)                             state_nx = S_IDLE;
                else if (int'(cnt) >= int'(gap_len) - 1)    state_nx = S_SETTLE;
            end
            default:   state_nx = S_IDLE;
        endcase
        // abort overrides every transition, including a pending timeout
        if (abort && state != S_IDLE) begin
            state_nx = S_IDLE;
            to_hit   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            win_len      <= '0;
            gap_len      <= '0;
            ro_en        <= 1'b0;
            cnt_clr      <= 1'b0;
            cnt_en       <= 1'b0;
            avg_en       <= 1'b0;
            avg_sum_en   <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nx;
            // counter restarts on every state change and saturates otherwise
            if (state_nx != state)     cnt <= '0;
            else if (cnt != 16'hFFFF)  cnt <= cnt + 16'd1;

            if (accept) begin
                win_len     <= (window_len == '0) ? WIN_W'(1) : window_len;
                gap_len     <= idle_gap;
                timeout_err <= 1'b0;
                overrun     <= 1'b0;
            end
            if (to_hit) timeout_err <= 1'b1;

            if (capture) begin
                result       <= avg_result;
                result_valid <= 1'b1;
                if (result_valid && !result_ack) overrun <= 1'b1;
            end else if (result_ack) begin
                result_valid <= 1'b0;
            end

            ro_en      <= (state_nx == S_SETTLE) || (state_nx == S_CLEAR) ||
                          (state_nx == S_WINDOW) || (state_nx == S_ACCUM);
            cnt_clr    <= (state_nx == S_CLEAR);
            cnt_en     <= (state_nx == S_WINDOW);
            avg_en     <= (state_nx == S_ACCUM) || (state_nx == S_CAPTURE);
            avg_sum_en <= (state_nx == S_ACCUM);
            busy       <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Directed bench: expected enable waveform is a queue built from phase lengths,
// result/flag model follows the capture/ack/start rules.
module tb_ro_meas_sequencer;
    localparam int S  = 16;
    localparam int TO = 64;

    logic        clk = 1'b0, reset = 1'b1;
    logic        start = 1'b0, cont_mode = 1'b0, abort = 1'b0;
    logic        avg_ready = 1'b0, result_ack = 1'b0;
    logic [15:0] window_len = '0, idle_gap = '0;
    logic [7:0]  avg_result = '0;
    logic        ro_en, cnt_clr, cnt_en, avg_en, avg_sum_en, busy;
    logic [7:0]  result;
    logic        result_valid, overrun, timeout_err;

    ro_meas_sequencer #(.SETTLE_CYC(S), .WIN_W(16), .RES_W(8), .ACC_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .cont_mode(cont_mode), .abort(abort),
        .window_len(window_len), .idle_gap(idle_gap), .avg_ready(avg_ready),
        .avg_result(avg_result), .result_ack(result_ack), .ro_en(ro_en), .cnt_clr(cnt_clr),
        .cnt_en(cnt_en), .avg_en(avg_en), .avg_sum_en(avg_sum_en), .busy(busy),
        .result(result), .result_valid(result_valid), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // {ro_en, cnt_clr, cnt_en, avg_en, avg_sum_en, busy}
    typedef logic [5:0] en_t;
    localparam en_t E_SET = 6'b100001;
    localparam en_t E_CLR = 6'b110001;
    localparam en_t E_WIN = 6'b101001;
    localparam en_t E_ACC = 6'b100111;
    localparam en_t E_CAP = 6'b000101;
    localparam en_t E_GAP = 6'b000001;

    en_t        q[$];
    logic [7:0] m_result = '0;
    logic       m_valid = 1'b0, m_ovr = 1'b0, m_to = 1'b0;
    int         tests = 0, fails = 0, cyc = 0;
    int         en_n = 0, clr_n = 0, en_first = 0, clr_last = 0;
    int         t0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // per-cycle compare against the expected waveform and result model
    initial forever begin
        en_t e;
        @(negedge clk);
        e = (q.size() > 0) ? q.pop_front() : 6'b0;
        tests++;
        if ({ro_en, cnt_clr, cnt_en, avg_en, avg_sum_en, busy} !== e || result !== m_result ||
            result_valid !== m_valid || overrun !== m_ovr || timeout_err !== m_to) begin
            fails++;
            $display("FAIL cycle %0d: got en=%b res=%h v=%b ovr=%b to=%b, want en=%b res=%h v=%b ovr=%b to=%b",
                     cyc, {ro_en, cnt_clr, cnt_en, avg_en, avg_sum_en, busy}, result,
                     result_valid, overrun, timeout_err, e, m_result, m_valid, m_ovr, m_to);
        end
    end

    initial forever begin
        @(negedge clk);
        if (cnt_en) begin
            if (en_n == 0) en_first = cyc;
            en_n++;
        end
        if (cnt_clr) begin
            clr_n++;
            clr_last = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input en_t e, input int n);
        repeat (n) q.push_back(e);
    endtask

    task automatic reset_counts();
        en_n = 0; clr_n = 0; en_first = 0; clr_last = 0;
    endtask

    task automatic do_start(input int w, input int g, input logic cont);
        window_len = 16'(w);
        idle_gap   = 16'(g);
        cont_mode  = cont;
        start      = 1'b1;
        step(1);
        start = 1'b0;
        m_ovr = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        step(1);
        result_ack = 1'b0;
        m_valid    = 1'b0;
    endtask

    // entered in the first SETTLE cycle; returns in the cycle after CAPTURE
    task automatic drive_conv(input int w, input int a, input logic [7:0] res,
                              input logic ack, input logic inj);
        int we;
        we = (w == 0) ? 1 : w;
        push(E_SET, S); push(E_CLR, 1); push(E_WIN, we); push(E_ACC, a); push(E_CAP, 1);
        avg_result = res;
        for (int i = 0; i < S + we + a; i++) begin
            if (inj && i == S + 3) begin
                start      = 1'b1;
                window_len = 16'd5;
            end
            step(1);
            start = 1'b0;
        end
        avg_ready = 1'b1;
        step(1);
        avg_ready  = 1'b0;
        result_ack = ack;
        step(1);
        result_ack = 1'b0;
        if (m_valid && !ack) m_ovr = 1'b1;
        m_valid  = 1'b1;
        m_result = res;
    endtask

    initial begin
        step(3);
        chk("reset_outs", {ro_en, cnt_clr, cnt_en, avg_en, avg_sum_en, busy,
                           result_valid, overrun, timeout_err}, 0);
        chk("reset_result", result, 0);
        reset = 1'b0;
        step(2);

        // async reset in the middle of the count window
        do_start(100, 0, 1'b0);
        push(E_SET, S); push(E_CLR, 1); push(E_WIN, 6);
        step(S + 1 + 5);
        chk("win_before_reset", cnt_en, 1);
        reset = 1'b1;
        q.delete();
        m_result = '0; m_valid = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
        #1;
        chk("reset_async", {ro_en, cnt_clr, cnt_en, avg_en, avg_sum_en, busy}, 0);
        step(1);
        reset = 1'b0;
        step(1);

        // single shot, window 100, ready in 5th ACCUM cycle
        reset_counts();
        t0 = cyc;
        do_start(100, 0, 1'b0);
        drive_conv(100, 5, 8'h5A, 1'b0, 1'b0);
        chk("latency", cyc - t0, 124);
        chk("cnt_en_100", en_n, 100);
        chk("result_5A", result, 8'h5A);
        chk("valid_5A", result_valid, 1);
        chk("busy_drop", busy, 0);
        do_ack();

        // continuous, gap 10, no ack between -> overrun
        do_start(8, 10, 1'b1);
        drive_conv(8, 3, 8'h10, 1'b0, 1'b0);
        push(E_GAP, 10);
        step(10);
        cont_mode = 1'b0;
        drive_conv(8, 3, 8'h11, 1'b0, 1'b0);
        chk("overrun_set", overrun, 1);
        chk("result_11", result, 8'h11);
        chk("busy_after_cont", busy, 0);
        do_ack();

        // ack coincides with second capture
        do_start(8, 10, 1'b1);
        drive_conv(8, 3, 8'h20, 1'b0, 1'b0);
        push(E_GAP, 10);
        step(10);
        cont_mode = 1'b0;
        drive_conv(8, 3, 8'h21, 1'b1, 1'b0);
        chk("ack_cap_valid", result_valid, 1);
        chk("ack_cap_ovr", overrun, 0);
        chk("result_21", result, 8'h21);

        // averager never ready -> timeout
        do_start(4, 0, 1'b0);
        push(E_SET, S); push(E_CLR, 1); push(E_WIN, 4); push(E_ACC, TO);
        step(S + 1 + 4 + TO);
        m_to = 1'b1;
        chk("timeout_set", timeout_err, 1);
        chk("timeout_idle", busy, 0);
        chk("timeout_result", result, 8'h21);
        do_start(4, 0, 1'b0);
        chk("timeout_clr", timeout_err, 0);

        // abort during SETTLE
        begin
            en_t keep;
            push(E_SET, S);
            step(3);
            abort = 1'b1;
            keep  = q[0];
            q.delete();
            q.push_back(keep);
            step(1);
            abort = 1'b0;
        end
        chk("abort_ro_en", ro_en, 0);
        chk("abort_valid", result_valid, 1);
        chk("abort_result", result, 8'h21);

        // start pulsed mid-window is ignored
        reset_counts();
        do_start(20, 0, 1'b0);
        drive_conv(20, 2, 8'h33, 1'b0, 1'b1);
        chk("inj_cnt_en_20", en_n, 20);
        chk("inj_result", result, 8'h33);
        chk("inj_overrun", overrun, 1);
        do_ack();

        // window_len = 0 behaves as 1
        reset_counts();
        do_start(0, 0, 1'b0);
        drive_conv(0, 2, 8'h44, 1'b0, 1'b0);
        chk("w0_cnt_en", en_n, 1);
        chk("w0_cnt_clr", clr_n, 1);
        chk("w0_clr_before_en", en_first - clr_last, 1);
        chk("w0_result", result, 8'h44);

        // start with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        step(1);
        chk("start_abort_idle", busy, 0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ro_meas_sequencer.md
Name: ro_meas_sequencer

Overview:
- Controller for the ring-oscillator temperature measurement path.
- Powers the ring oscillator, waits for it to settle, opens a gated edge-count window, then runs the downstream averaging block (en / sum_en / ready handshake) and latches its result.
- Supports single-shot and continuous (periodic) conversions; the result is held with a valid/ack handshake to the readout logic.

Parameters:
- SETTLE_CYC, 16, clk cycles ro_en must be high before counting starts (min 1)
- WIN_W, 16, width of window_len
- RES_W, 8, width of averaged result
- ACC_TIMEOUT, 64, max cycles waiting for avg_ready before error

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a conversion; ignored while busy
- cont_mode  in  1  1 = re-arm automatically after each conversion
- abort  in  1  synchronous abort; return to IDLE next cycle
- window_len  in  WIN_W  count-window length in cycles; sampled on accepted start
- idle_gap  in  16  cycles between conversions in continuous mode; sampled on accepted start
- avg_ready  in  1  averager sum-ready pulse
- avg_result  in  RES_W  averager output register
- result_ack  in  1  consumer acknowledges result
- ro_en  out  1  ring-oscillator enable
- cnt_clr  out  1  edge-counter synchronous clear
- cnt_en  out  1  edge-counter gate
- avg_en  out  1  averager enable
- avg_sum_en  out  1  averager accumulate enable
- busy  out  1  conversion in progress (state != IDLE)
- result  out  RES_W  last captured average
- result_valid  out  1  result unread
- overrun  out  1  sticky: unread result overwritten
- timeout_err  out  1  sticky: avg_ready never arrived

Behaviour:
- Reset (async): state IDLE, all outputs 0, internal counters 0, latched window_len/idle_gap 0.
- All outputs registered, decoded from the registered state.
- States and output values:
  - IDLE: all enables 0.
  - SETTLE: ro_en=1.
  - CLEAR: ro_en=1, cnt_clr=1.
  - WINDOW: ro_en=1, cnt_en=1.
  - ACCUM: ro_en=1, avg_en=1, avg_sum_en=1.
  - CAPTURE: avg_en=1.
  - GAP: all enables 0.
- IDLE -> SETTLE on start=1:
  - latch window_len and idle_gap;
  - window_len=0 is treated as 1;
  - clear timeout_err and overrun.
- SETTLE lasts exactly SETTLE_CYC cycles, then CLEAR for exactly 1 cycle, then WINDOW.
- WINDOW lasts exactly the latched window_len cycles, so cnt_en is high for window_len cycles. Then ACCUM.
- ACCUM: the first cycle with avg_ready=1 sampled moves to CAPTURE.
  - If ACC_TIMEOUT cycles pass in ACCUM without avg_ready: set timeout_err, go to IDLE, result unchanged.
- CAPTURE (1 cycle): avg_result is latched into result at the edge ending CAPTURE; result_valid <= 1.
  - If result_valid was already 1 and result_ack is not high that cycle: overrun <= 1.
- After CAPTURE:
  - cont_mode=1 (sampled in CAPTURE) -> GAP.
  - cont_mode=0 -> IDLE.
- GAP lasts the latched idle_gap cycles (0 -> straight to SETTLE), then SETTLE.
  - cont_mode=0 sampled during GAP -> IDLE next cycle.
- cont_mode deasserted mid-conversion: the current conversion completes, then IDLE.
- result_ack=1 clears result_valid next cycle. If ack coincides with the CAPTURE edge, the capture wins: valid stays 1, no overrun.
- abort=1 in any non-IDLE state:
  - next state IDLE, all enables 0;
  - result, result_valid and sticky flags unchanged.
  - abort has priority over all transitions.
- start while busy is ignored; start together with abort in IDLE is ignored.
- Nominal single-shot latency, start to result_valid: 1 + SETTLE_CYC + 1 + window_len + (ACCUM cycles) + 1 cycles.
- State counters are 16 bit and saturate, never wrap.

Test Plan:
- Reset mid-WINDOW -> all outputs 0 immediately, state IDLE. Then start with SETTLE_CYC=16, window_len=100, avg_ready 5 cycles into ACCUM, avg_result=8'h5A:
  - cnt_en high exactly 100 cycles;
  - result=8'h5A, result_valid=1;
  - busy drops next cycle.
- cont_mode=1, idle_gap=10, avg_result 8'h10 then 8'h11 with no ack between:
  - two conversions separated by 10 idle cycles;
  - second capture sets overrun=1, result=8'h11.
- result_ack on the same cycle as the second CAPTURE edge -> result_valid stays 1, overrun stays 0.
- avg_ready held 0 -> timeout_err=1 after 64 ACCUM cycles, state IDLE, result unchanged. Next start clears timeout_err.
- abort in SETTLE; separately, start pulsed while in WINDOW:
  - abort: ro_en=0 next cycle, result_valid unchanged;
  - start in WINDOW: ignored, window length unaffected.
- window_len=0 -> cnt_en high exactly 1 cycle; cnt_clr high exactly 1 cycle, immediately before cnt_en.
